// File: rtl/wb_io_arbiter.sv
// Two-master (CPU = master 0, DMA = master 1) Wishbone arbiter onto a single IO slave port.
// Define WB_ARB_TIMEOUT_EN to build in the hung-slave watchdog (limit set by TIMEOUT_CYCLES).
module wb_io_arbiter #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_n_i,
   input  logic [31:0] wbm0_adr_i,
   input  logic [31:0] wbm0_dat_i,
   input  logic [3:0]  wbm0_sel_i,
   input  logic        wbm0_we_i,
   input  logic        wbm0_cyc_i,
   input  logic        wbm0_stb_i,
   input  logic [2:0]  wbm0_cti_i,
   input  logic [1:0]  wbm0_bte_i,
   output logic [31:0] wbm0_dat_o,
   output logic        wbm0_ack_o,
   output logic        wbm0_err_o,
   output logic        wbm0_rty_o,
   input  logic [31:0] wbm1_adr_i,
   input  logic [31:0] wbm1_dat_i,
   input  logic [3:0]  wbm1_sel_i,
   input  logic        wbm1_we_i,
   input  logic        wbm1_cyc_i,
   input  logic        wbm1_stb_i,
   input  logic [2:0]  wbm1_cti_i,
   input  logic [1:0]  wbm1_bte_i,
   output logic [31:0] wbm1_dat_o,
   output logic        wbm1_ack_o,
   output logic        wbm1_err_o,
   output logic        wbm1_rty_o,
   output logic [31:0] wbs_adr_o,
   output logic [31:0] wbs_dat_o,
   output logic [3:0]  wbs_sel_o,
   output logic        wbs_we_o,
   output logic        wbs_cyc_o,
   output logic        wbs_stb_o,
   output logic [2:0]  wbs_cti_o,
   output logic [1:0]  wbs_bte_o,
   input  logic [31:0] wbs_dat_i,
   input  logic        wbs_ack_i,
   input  logic        wbs_err_i,
   input  logic        wbs_rty_i
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("wb_io_arbiter: TIMEOUT_CYCLES must be within 1..65535");
   end

   typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

   state_t state, state_next;
   logic   last_grant, last_grant_next;
   logic   owner_cyc;
   logic   timeout_hit;

   // last_grant always names the current owner while in OWN0/OWN1/ABORT
   assign owner_cyc = last_grant ? wbm1_cyc_i : wbm0_cyc_i;

`ifdef WB_ARB_TIMEOUT_EN
   logic        rsp_any;
   logic [15:0] wdog_cnt;

   assign rsp_any = wbs_ack_i | wbs_err_i | wbs_rty_i;

   // Counting only stalled strobe cycles; every grant passes through IDLE, which clears it
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         wdog_cnt <= '0;
      end else if (state == IDLE || rsp_any) begin
         wdog_cnt <= '0;
      end else if ((state == OWN0 || state == OWN1) && wbs_stb_o) begin
         wdog_cnt <= wdog_cnt + 16'd1;
      end
   end

   assign timeout_hit = (state == OWN0 || state == OWN1) && owner_cyc && !rsp_any &&
                        (wdog_cnt == 16'(TIMEOUT_CYCLES));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n_i) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_next;
         last_grant <= last_grant_next;
      end
   end

   // Contention goes to whichever master did not win last time
   always_comb begin
      state_next      = state;
      last_grant_next = last_grant;
      case (state)
         IDLE: begin
            if (wbm0_cyc_i && wbm1_cyc_i) begin
               state_next      = last_grant ? OWN0 : OWN1;
               last_grant_next = ~last_grant;
            end else if (wbm0_cyc_i) begin
               state_next      = OWN0;
               last_grant_next = 1'b0;
            end else if (wbm1_cyc_i) begin
               state_next      = OWN1;
               last_grant_next = 1'b1;
            end
         end
         OWN0, OWN1: begin
            if (!owner_cyc)       state_next = IDLE;
            else if (timeout_hit) state_next = ABORT;
         end
         ABORT: begin
            if (!owner_cyc) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are forced low whenever reset is asserted, before the state has even moved
   always_comb begin
      wbs_adr_o  = '0;
      wbs_dat_o  = '0;
      wbs_sel_o  = '0;
      wbs_we_o   = 1'b0;
      wbs_cyc_o  = 1'b0;
      wbs_stb_o  = 1'b0;
      wbs_cti_o  = '0;
      wbs_bte_o  = '0;
      wbm0_dat_o = '0;
      wbm1_dat_o = '0;
      wbm0_ack_o = 1'b0;
      wbm0_err_o = 1'b0;
      wbm0_rty_o = 1'b0;
      wbm1_ack_o = 1'b0;
      wbm1_err_o = 1'b0;
      wbm1_rty_o = 1'b0;
      if (wb_rst_n_i) begin
         wbm0_dat_o = wbs_dat_i;
         wbm1_dat_o = wbs_dat_i;
         case (state)
            OWN0: begin
               wbs_adr_o  = wbm0_adr_i;
               wbs_dat_o  = wbm0_dat_i;
               wbs_sel_o  = wbm0_sel_i;
               wbs_we_o   = wbm0_we_i;
               wbs_cyc_o  = wbm0_cyc_i;
               wbs_stb_o  = wbm0_stb_i;
               wbs_cti_o  = wbm0_cti_i;
               wbs_bte_o  = wbm0_bte_i;
               wbm0_ack_o = wbs_ack_i;
               wbm0_err_o = wbs_err_i | timeout_hit;
               wbm0_rty_o = wbs_rty_i;
            end
            OWN1: begin
               wbs_adr_o  = wbm1_adr_i;
               wbs_dat_o  = wbm1_dat_i;
               wbs_sel_o  = wbm1_sel_i;
               wbs_we_o   = wbm1_we_i;
               wbs_cyc_o  = wbm1_cyc_i;
               wbs_stb_o  = wbm1_stb_i;
               wbs_cti_o  = wbm1_cti_i;
               wbs_bte_o  = wbm1_bte_i;
               wbm1_ack_o = wbs_ack_i;
               wbm1_err_o = wbs_err_i | timeout_hit;
               wbm1_rty_o = wbs_rty_i;
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Self-checking bench for wb_io_arbiter: directed scenarios plus randomized two-master traffic
// compared against a transaction-level ownership model. Inputs change and outputs are sampled at negedge.
module tb_wb_io_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] m0_adr, m0_dat, m1_adr, m1_dat;
   logic [3:0]  m0_sel, m1_sel;
   logic        m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
   logic [2:0]  m0_cti, m1_cti;
   logic [1:0]  m0_bte, m1_bte;
   logic [31:0] m0_rdat, m1_rdat;
   logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
   logic [31:0] s_adr, s_wdat, s_rdat;
   logic [3:0]  s_sel;
   logic        s_we, s_cyc, s_stb, s_ack, s_err, s_rty;
   logic [2:0]  s_cti;
   logic [1:0]  s_bte;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   wb_io_arbiter #(.TIMEOUT_CYCLES(8)) dut (
      .wb_clk_i(clk), .wb_rst_n_i(rst_n),
      .wbm0_adr_i(m0_adr), .wbm0_dat_i(m0_dat), .wbm0_sel_i(m0_sel), .wbm0_we_i(m0_we),
      .wbm0_cyc_i(m0_cyc), .wbm0_stb_i(m0_stb), .wbm0_cti_i(m0_cti), .wbm0_bte_i(m0_bte),
      .wbm0_dat_o(m0_rdat), .wbm0_ack_o(m0_ack), .wbm0_err_o(m0_err), .wbm0_rty_o(m0_rty),
      .wbm1_adr_i(m1_adr), .wbm1_dat_i(m1_dat), .wbm1_sel_i(m1_sel), .wbm1_we_i(m1_we),
      .wbm1_cyc_i(m1_cyc), .wbm1_stb_i(m1_stb), .wbm1_cti_i(m1_cti), .wbm1_bte_i(m1_bte),
      .wbm1_dat_o(m1_rdat), .wbm1_ack_o(m1_ack), .wbm1_err_o(m1_err), .wbm1_rty_o(m1_rty),
      .wbs_adr_o(s_adr), .wbs_dat_o(s_wdat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
      .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
      .wbs_dat_i(s_rdat), .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty)
   );

   task automatic clear_inputs();
      m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      m0_cti = '0; m0_bte = '0;
      m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      m1_cti = '0; m1_bte = '0;
      s_rdat = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle_bus();
      @(negedge clk);
      clear_inputs();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b0;
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h1234_5678;
      s_ack = 1'b1; s_rdat = 32'hCAFE_F00D;
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_cyc_stb got=%b%b exp=00", s_cyc, s_stb);
      end
      checks++;
      if (s_adr !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_adr got=%h exp=00000000", s_adr);
      end
      checks++;
      if (m0_ack !== 1'b0 || m0_rdat !== 32'h0) begin
         errors++; $display("[TB] FAIL reset_m0_resp got ack=%b dat=%h exp ack=0 dat=0", m0_ack, m0_rdat);
      end
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single_master();
      @(negedge clk);
      m0_adr = 32'h0000_1000; m0_we = 1'b0; m0_sel = 4'hF; m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 1'b0) begin
         errors++; $display("[TB] FAIL single_cycle0_cyc got=%b exp=0", s_cyc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h0000_1000) begin
         errors++; $display("[TB] FAIL single_grant got cyc=%b adr=%h exp cyc=1 adr=00001000", s_cyc, s_adr);
      end
      s_ack = 1'b1; s_rdat = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (m0_ack !== 1'b1 || m0_rdat !== 32'hDEAD_BEEF) begin
         errors++; $display("[TB] FAIL single_ack got ack=%b dat=%h exp ack=1 dat=deadbeef", m0_ack, m0_rdat);
      end
      checks++;
      if (m1_ack !== 1'b0) begin
         errors++; $display("[TB] FAIL single_m1_ack got=%b exp=0", m1_ack);
      end
      @(negedge clk);
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      #1;
      checks++;
      if (s_cyc !== 1'b0) begin
         errors++; $display("[TB] FAIL single_release_cyc got=%b exp=0", s_cyc);
      end
      idle_bus();
   endtask

   // Both masters keep requesting; the owner releases for one cycle then re-requests
   task automatic test_contention();
      logic [31:0] exp_adr;
      do_reset();
      m0_adr = 32'h0000_00A0; m1_adr = 32'h0000_00B0;
      m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
      @(negedge clk);
      for (int r = 0; r < 4; r++) begin
         exp_adr = (r % 2 == 0) ? 32'h0000_00A0 : 32'h0000_00B0;
         #1;
         checks++;
         if (s_cyc !== 1'b1 || s_adr !== exp_adr) begin
            errors++; $display("[TB] FAIL contention_round%0d got cyc=%b adr=%h exp cyc=1 adr=%h", r, s_cyc, s_adr, exp_adr);
         end
         @(negedge clk);
         if (r % 2 == 0) m0_cyc = 1'b0; else m1_cyc = 1'b0;
         #1;
         checks++;
         if (s_cyc !== 1'b0) begin
            errors++; $display("[TB] FAIL contention_release%0d got cyc=%b exp=0", r, s_cyc);
         end
         @(negedge clk);
         m0_cyc = 1'b1; m1_cyc = 1'b1;
         #1;
         checks++;
         if (s_cyc !== 1'b0) begin
            errors++; $display("[TB] FAIL contention_gap%0d got cyc=%b exp=0", r, s_cyc);
         end
         @(negedge clk);
      end
      idle_bus();
   endtask

   task automatic test_burst_hold();
      logic [4:0] stb_pat;
      int acks;
      stb_pat = 5'b11011;
      acks = 0;
      @(negedge clk);
      m1_adr = 32'h0000_2000; m1_cti = 3'b010; m1_cyc = 1'b1; m1_stb = 1'b1;
      m0_adr = 32'h0000_3000;
      @(negedge clk);
      m0_cyc = 1'b1; m0_stb = 1'b1;
      for (int b = 0; b < 5; b++) begin
         m1_stb = stb_pat[4-b];
         s_ack  = stb_pat[4-b];
         #1;
         checks++;
         if (s_cyc !== 1'b1 || s_adr !== 32'h0000_2000 || s_cti !== 3'b010) begin
            errors++; $display("[TB] FAIL burst_owner%0d got cyc=%b adr=%h cti=%b exp cyc=1 adr=00002000 cti=010", b, s_cyc, s_adr, s_cti);
         end
         checks++;
         if (m1_ack !== stb_pat[4-b] || m0_ack !== 1'b0) begin
            errors++; $display("[TB] FAIL burst_ack%0d got m1=%b m0=%b exp m1=%b m0=0", b, m1_ack, m0_ack, stb_pat[4-b]);
         end
         if (m1_ack === 1'b1) acks++;
         @(negedge clk);
      end
      checks++;
      if (acks != 4) begin
         errors++; $display("[TB] FAIL burst_ack_count got=%0d exp=4", acks);
      end
      s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
      #1;
      checks++;
      if (s_cyc !== 1'b0) begin
         errors++; $display("[TB] FAIL burst_release got cyc=%b exp=0", s_cyc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b0) begin
         errors++; $display("[TB] FAIL burst_gap got cyc=%b exp=0", s_cyc);
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h0000_3000) begin
         errors++; $display("[TB] FAIL burst_next_owner got cyc=%b adr=%h exp cyc=1 adr=00003000", s_cyc, s_adr);
      end
      idle_bus();
   endtask

   task automatic test_timeout();
      int  n;
      bit  seen;
      int  bad;
      @(negedge clk);
      m0_adr = 32'h0000_4000; m0_dat = 32'h5555_AAAA; m0_we = 1'b1; m0_sel = 4'hF;
      m0_cyc = 1'b1; m0_stb = 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
      n = 0; seen = 1'b0; bad = 0;
      for (int i = 1; i <= 40 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (m0_err === 1'b1) begin
            seen = 1'b1; n = i;
         end
      end
      checks++;
      if (!seen || n != 9) begin
         errors++; $display("[TB] FAIL timeout_err_cycle got seen=%b cycle=%0d exp seen=1 cycle=9", seen, n);
      end
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      checks++;
      if (m0_err !== 1'b0 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
         errors++; $display("[TB] FAIL timeout_abort got err=%b cyc=%b stb=%b exp 0 0 0", m0_err, s_cyc, s_stb);
      end
      checks++;
      if (m0_ack !== 1'b0) begin
         errors++; $display("[TB] FAIL timeout_late_ack got=%b exp=0", m0_ack);
      end
      @(negedge clk);
      s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
      @(negedge clk);
      m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0;
      s_ack = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || m0_ack !== 1'b0) begin
         errors++; $display("[TB] FAIL timeout_idle got cyc=%b ack=%b exp 0 0", s_cyc, m0_ack);
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b1 || m0_ack !== 1'b1) begin
         errors++; $display("[TB] FAIL timeout_regrant got cyc=%b ack=%b exp 1 1", s_cyc, m0_ack);
      end
`else
      n = 0; seen = 1'b0; bad = 0;
      @(negedge clk);
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         #1;
         if (m0_err !== 1'b0 || s_cyc !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("[TB] FAIL hang_hold got bad_cycles=%0d exp=0", bad);
      end
      checks++;
      if (s_adr !== 32'h0000_4000 || s_we !== 1'b1 || s_wdat !== 32'h5555_AAAA) begin
         errors++; $display("[TB] FAIL hang_passthru got adr=%h we=%b dat=%h exp 00004000 1 5555aaaa", s_adr, s_we, s_wdat);
      end
`endif
      idle_bus();
   endtask

   task automatic test_reset_midop();
      @(negedge clk);
      m1_adr = 32'h0000_5000; m1_cyc = 1'b1; m1_stb = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h0000_5000) begin
         errors++; $display("[TB] FAIL midop_owner got cyc=%b adr=%h exp cyc=1 adr=00005000", s_cyc, s_adr);
      end
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      s_ack = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || m1_ack !== 1'b0) begin
         errors++; $display("[TB] FAIL midop_reset got cyc=%b ack=%b exp 0 0", s_cyc, m1_ack);
      end
      rst_n = 1'b1;
      s_ack = 1'b0;
      m0_adr = 32'h0000_6000; m0_cyc = 1'b1; m0_stb = 1'b1;
      #1;
      checks++;
      if (s_cyc !== 1'b0 || m1_ack !== 1'b0) begin
         errors++; $display("[TB] FAIL midop_after got cyc=%b ack=%b exp 0 0", s_cyc, m1_ack);
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_cyc !== 1'b1 || s_adr !== 32'h0000_6000) begin
         errors++; $display("[TB] FAIL midop_contention got cyc=%b adr=%h exp cyc=1 adr=00006000", s_cyc, s_adr);
      end
      idle_bus();
   endtask

   // Reference: owner is -1 (bus idle) or a master index; a released bus always spends a cycle idle
   task automatic test_random_arbitration();
      int          owner, last;
      bit          want [2];
      bit          stb  [2];
      int          hold [2];
      logic [31:0] adr  [2];
      logic        exp_cyc;
      logic [31:0] rdat;
      logic        ack;
      do_reset();
      owner = -1; last = 1;
      for (int k = 0; k < 2; k++) begin
         want[k] = 1'b0; stb[k] = 1'b0; hold[k] = 0; adr[k] = '0;
      end
      for (int c = 0; c < 300; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!want[k]) begin
               if ($urandom_range(0, 2) == 0) begin
                  want[k] = 1'b1;
                  adr[k]  = $urandom;
                  hold[k] = $urandom_range(1, 5);
               end
            end else if (owner == k) begin
               if (hold[k] == 0) want[k] = 1'b0;
               else hold[k]--;
            end
            stb[k] = want[k] && ($urandom_range(0, 3) != 0);
         end
         m0_cyc = want[0]; m0_stb = stb[0]; m0_adr = adr[0];
         m1_cyc = want[1]; m1_stb = stb[1]; m1_adr = adr[1];
         ack  = 1'($urandom_range(0, 1));
         rdat = $urandom;
         s_ack = ack; s_rdat = rdat;
         #1;
         exp_cyc = (owner >= 0) ? want[owner] : 1'b0;
         checks++;
         if (s_cyc !== exp_cyc) begin
            errors++; $display("[TB] FAIL rand_cyc c=%0d got=%b exp=%b", c, s_cyc, exp_cyc);
         end
         if (owner >= 0) begin
            checks++;
            if (s_adr !== adr[owner] || s_stb !== stb[owner]) begin
               errors++; $display("[TB] FAIL rand_owner c=%0d got adr=%h stb=%b exp adr=%h stb=%b", c, s_adr, s_stb, adr[owner], stb[owner]);
            end
         end
         checks++;
         if (m0_ack !== (owner == 0 && ack) || m1_ack !== (owner == 1 && ack)) begin
            errors++; $display("[TB] FAIL rand_ack c=%0d got m0=%b m1=%b owner=%0d ack=%b", c, m0_ack, m1_ack, owner, ack);
         end
         checks++;
         if (m0_rdat !== rdat || m1_rdat !== rdat) begin
            errors++; $display("[TB] FAIL rand_rdat c=%0d got %h %h exp %h", c, m0_rdat, m1_rdat, rdat);
         end
         if (owner >= 0) begin
            if (!want[owner]) owner = -1;
         end else if (want[0] && want[1]) begin
            owner = 1 - last; last = owner;
         end else if (want[0]) begin
            owner = 0; last = 0;
         end else if (want[1]) begin
            owner = 1; last = 1;
         end
      end
      idle_bus();
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      $display("[TB] starting wb_io_arbiter bench");
      test_reset();
      test_single_master();
      test_contention();
      test_burst_hold();
      test_timeout();
      test_reset_midop();
      test_random_arbitration();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
